// File: rtl/elc3_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// state encodings, latency helper and width-generic magnitude helpers.
// No ports; imported by muldiv_unit.
package elc3_pkg;

   typedef enum logic [1:0] {
      MULU = 2'd0,
      MULS = 2'd1,
      DIVU = 2'd2,
      DIVS = 2'd3
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   // Start edge to Done cycle: WIDTH iterations, one fix-up cycle, one done cycle.
   function automatic int muldiv_lat(input int w);
      return w + 2;
   endfunction

   // Two's complement negate of the low w bits of v (w up to 64).
   // For w==64 the shift yields 0 and the mask wraps to all ones.
   function automatic logic [63:0] neg_w(input logic [63:0] v, input int w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      return (~v + 64'd1) & mask;
   endfunction

   // Magnitude of the w-bit signed value in the low bits of v.
   // The most negative value maps to itself, read as unsigned.
   function automatic logic [63:0] abs_w(input logic [63:0] v, input int w);
      return v[w-1] ? neg_w(v, w) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide, one result bit per cycle.
// Ports: Clk/Reset; Start/Op/A/B request; Busy, one-cycle Done pulse,
// Result (MUL: product, DIV: {remainder, quotient}) and DivByZero held until the next op's fix-up.
module muldiv_unit
   import elc3_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 Busy,
   output logic                 Done,
   output logic [2*WIDTH-1:0]   Result,
   output logic                 DivByZero
);

   localparam int CW         = $clog2(WIDTH + 1);
   localparam int MULDIV_LAT = muldiv_lat(WIDTH);

   muldiv_state_e       state, state_nxt;
   logic                accept;
   logic [CW-1:0]       cnt;
   logic [2*WIDTH-1:0]  acc;        // MUL: {partial product, multiplier}; DIV: {rem, quo}
   logic [WIDTH-1:0]    opb;        // MUL: multiplicand; DIV: divisor
   muldiv_op_e          op_q;
   logic                sign_a, sign_b;

   // ---------------- control FSM ----------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         IDLE: if (Start) begin
            accept    = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            Busy = 1'b1;
            if (cnt == CW'(1)) state_nxt = FIX;
         end
         FIX: begin
            Busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            Done = 1'b1;
            if (Start) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- operand capture ----------------
   logic [WIDTH-1:0] a_in, b_in;
   always_comb begin
      a_in = A;
      b_in = B;
      if (Op[0]) begin
         a_in = WIDTH'(abs_w(64'(A), WIDTH));
         b_in = WIDTH'(abs_w(64'(B), WIDTH));
      end
   end

   // ---------------- one iteration ----------------
   // MUL: conditional add into the upper half, then shift the whole accumulator right.
   logic [WIDTH:0]      mul_add;
   logic [2*WIDTH-1:0]  mul_next;
   assign mul_add  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
   assign mul_next = {mul_add, acc[WIDTH-1:1]};

   // DIV: the shifted remainder needs WIDTH+1 bits because a divisor with its
   // MSB set allows a remainder with its MSB set before the shift.
   logic [WIDTH:0]      partial, sub;
   logic                borrow;
   logic [2*WIDTH-1:0]  div_next;
   assign partial         = acc[2*WIDTH-1:WIDTH-1];
   assign {borrow, sub}   = {1'b0, partial} - {2'b00, opb};
   assign div_next        = {borrow ? partial[WIDTH-1:0] : WIDTH'(sub), acc[WIDTH-2:0], ~borrow};

   // ---------------- sign fix-up ----------------
   logic [WIDTH-1:0]    rem, quo, rem_fix, quo_fix;
   logic [2*WIDTH-1:0]  fix_result;
   logic                b_zero;
   always_comb begin
      rem        = acc[2*WIDTH-1:WIDTH];
      quo        = acc[WIDTH-1:0];
      b_zero     = op_q[1] && (opb == '0);
      rem_fix    = rem;
      quo_fix    = quo;
      fix_result = acc;
      case (op_q)
         MULS: if (sign_a ^ sign_b)
                  fix_result = (2*WIDTH)'(neg_w(64'(acc), 2*WIDTH));
         DIVS: begin
            // A zero divisor leaves the all-ones quotient alone; the remainder
            // still gets the dividend's sign, which restores the raw A.
            if ((sign_a ^ sign_b) && !b_zero) quo_fix = WIDTH'(neg_w(64'(quo), WIDTH));
            if (sign_a)                       rem_fix = WIDTH'(neg_w(64'(rem), WIDTH));
            fix_result = {rem_fix, quo_fix};
         end
         default: fix_result = acc;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt       <= '0;
         acc       <= '0;
         opb       <= '0;
         op_q      <= MULU;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         Result    <= '0;
         DivByZero <= 1'b0;
      end else if (accept) begin
         op_q   <= muldiv_op_e'(Op);
         sign_a <= Op[0] & A[WIDTH-1];
         sign_b <= Op[0] & B[WIDTH-1];
         cnt    <= CW'(MULDIV_LAT - 2);
         if (Op[1]) begin
            acc <= {{WIDTH{1'b0}}, a_in};
            opb <= b_in;
         end else begin
            acc <= {{WIDTH{1'b0}}, b_in};
            opb <= a_in;
         end
      end else if (state == CALC) begin
         cnt <= cnt - CW'(1);
         acc <= op_q[1] ? div_next : mul_next;
      end else if (state == FIX) begin
         Result    <= fix_result;
         DivByZero <= b_zero;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=8, 16 and 4.
// Directed vectors with fixed expectations plus random ops against an
// integer-arithmetic reference model; checks latency, Busy and Done pulse.
module tb_muldiv_unit;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;
   logic Reset;

   logic        start8, start16, start4;
   logic [1:0]  op8, op16, op4;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic [3:0]  a4, b4;
   logic        busy8, busy16, busy4, done8, done16, done4, dz8, dz16, dz4;
   logic [15:0] result8;
   logic [31:0] result16;
   logic [7:0]  result4;

   muldiv_unit #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Reset(Reset), .Start(start8), .Op(op8), .A(a8), .B(b8),
      .Busy(busy8), .Done(done8), .Result(result8), .DivByZero(dz8));
   muldiv_unit #(.WIDTH(16)) dut16 (
      .Clk(Clk), .Reset(Reset), .Start(start16), .Op(op16), .A(a16), .B(b16),
      .Busy(busy16), .Done(done16), .Result(result16), .DivByZero(dz16));
   muldiv_unit #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .Start(start4), .Op(op4), .A(a4), .B(b4),
      .Busy(busy4), .Done(done4), .Result(result4), .DivByZero(dz4));

   int tests_run = 0;
   int tests_failed = 0;
   int cur_w = 8;

   logic        sel_busy, sel_done, sel_dz;
   logic [63:0] sel_res;
   always_comb begin
      case (cur_w)
         4:  begin sel_busy = busy4;  sel_done = done4;  sel_dz = dz4;  sel_res = 64'(result4);  end
         16: begin sel_busy = busy16; sel_done = done16; sel_dz = dz16; sel_res = 64'(result16); end
         default: begin sel_busy = busy8; sel_done = done8; sel_dz = dz8; sel_res = 64'(result8); end
      endcase
   end

   // Directed vectors, WIDTH=8
   logic [1:0]  d_op  [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
   logic [7:0]  d_a   [8] = '{8'hFF, 8'hFD, 8'h80, 8'h64, 8'hF9, 8'h80, 8'h2A, 8'h02};
   logic [7:0]  d_b   [8] = '{8'hFF, 8'h07, 8'h80, 8'h07, 8'h02, 8'hFF, 8'h00, 8'h03};
   logic [15:0] d_res [8] = '{16'hFE01, 16'hFFEB, 16'h4000, 16'h020E,
                              16'hFFFD, 16'h0080, 16'h2AFF, 16'h0006};
   logic        d_dz  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // Reference model: plain signed/unsigned integer arithmetic.
   function automatic void ref_model(input int w, input logic [1:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [63:0] res, output logic dz);
      longint m, ua, ub, sa, sb, q, r, p;
      logic [63:0] mask_w, mask_2w, qv, rv, pv;
      m       = longint'(1) << w;
      mask_w  = (64'd1 << w) - 64'd1;
      mask_2w = (64'd1 << (2 * w)) - 64'd1;
      ua = longint'(a) & (m - 1);
      ub = longint'(b) & (m - 1);
      sa = (op[0] && ua >= m / 2) ? ua - m : ua;
      sb = (op[0] && ub >= m / 2) ? ub - m : ub;
      dz = 1'b0;
      if (!op[1]) begin
         p   = sa * sb;
         pv  = p;
         res = pv & mask_2w;
      end else if (ub == 0) begin
         dz  = 1'b1;
         rv  = ua;
         res = (rv << w) | mask_w;
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         qv  = q;
         rv  = r;
         res = ((rv & mask_w) << w) | (qv & mask_w);
      end
   endfunction

   task automatic drive(input int w, input logic st, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      case (w)
         4:  begin start4  = st; op4  = op; a4  = a[3:0];  b4  = b[3:0];  end
         16: begin start16 = st; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
         default: begin start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
      endcase
   endtask

   // Issue one op with a single-edge Start, then scramble the inputs.
   // lat is the cycle in which Done was seen (accepting edge starts cycle 1).
   task automatic run_op(input int w, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [63:0] res, output logic dz,
                         output int lat, output int busy_n, output logic done_after);
      cur_w = w;
      @(negedge Clk);
      drive(w, 1'b1, op, a, b);
      @(negedge Clk);
      drive(w, 1'b0, 2'($urandom), $urandom, $urandom);
      lat    = 1;
      busy_n = 0;
      while (sel_done !== 1'b1 && lat < 200) begin
         if (sel_busy === 1'b1) busy_n++;
         @(negedge Clk);
         lat++;
      end
      if (sel_busy === 1'b1) busy_n++;
      res = sel_res;
      dz  = sel_dz;
      @(negedge Clk);
      done_after = sel_done;
   endtask

   task automatic test_reset;
      #1;
      tests_run++;
      if ({busy8, done8, result8, dz8} !== '0) begin
         tests_failed++;
         $display("FAIL reset_w8 got busy=%b done=%b res=%h dz=%b, want all 0", busy8, done8, result8, dz8);
      end
      tests_run++;
      if ({busy16, done16, result16, dz16, busy4, done4, result4, dz4} !== '0) begin
         tests_failed++;
         $display("FAIL reset_w16_w4 got res16=%h res4=%h, want all outputs 0", result16, result4);
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      tests_run++;
      if ({busy8, done8, result8, dz8} !== '0) begin
         tests_failed++;
         $display("FAIL idle_after_reset got busy=%b done=%b res=%h dz=%b, want all 0", busy8, done8, result8, dz8);
      end
   endtask

   task automatic test_directed;
      logic [63:0] res;
      logic dz, done_after;
      int lat, busy_n;
      for (int i = 0; i < 8; i++) begin
         run_op(8, d_op[i], 32'(d_a[i]), 32'(d_b[i]), res, dz, lat, busy_n, done_after);
         tests_run++;
         if (res !== 64'(d_res[i])) begin
            tests_failed++;
            $display("FAIL dir%0d_result got %h want %h", i, res, d_res[i]);
         end
         tests_run++;
         if (dz !== d_dz[i]) begin
            tests_failed++;
            $display("FAIL dir%0d_divbyzero got %b want %b", i, dz, d_dz[i]);
         end
         tests_run++;
         if (lat !== 10) begin
            tests_failed++;
            $display("FAIL dir%0d_latency got %0d want 10", i, lat);
         end
         tests_run++;
         if (busy_n !== 9) begin
            tests_failed++;
            $display("FAIL dir%0d_busy_cycles got %0d want 9", i, busy_n);
         end
         tests_run++;
         if (done_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL dir%0d_done_pulse got done=%b next cycle want 0", i, done_after);
         end
      end
   endtask

   task automatic test_start_ignored;
      int lat, extra;
      cur_w = 8;
      @(negedge Clk);
      drive(8, 1'b1, 2'd0, 32'h12, 32'h34);
      @(negedge Clk);
      drive(8, 1'b0, 2'd0, 32'h12, 32'h34);
      lat = 1;
      while (sel_done !== 1'b1 && lat < 200) begin
         if (lat == 3) drive(8, 1'b1, 2'd2, 32'hFF, 32'h01);
         if (lat == 4) drive(8, 1'b0, 2'd2, 32'hFF, 32'h01);
         @(negedge Clk);
         lat++;
      end
      tests_run++;
      if (lat !== 10) begin
         tests_failed++;
         $display("FAIL ignored_latency got %0d want 10", lat);
      end
      tests_run++;
      if (sel_res !== 64'h03A8) begin
         tests_failed++;
         $display("FAIL ignored_result got %h want 03a8", sel_res);
      end
      extra = 0;
      repeat (12) begin
         @(negedge Clk);
         if (sel_done === 1'b1 || sel_busy === 1'b1) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("FAIL ignored_no_queue got %0d active cycles want 0", extra);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      cur_w = 8;
      @(negedge Clk);
      drive(8, 1'b1, 2'd1, 32'h85, 32'h05);
      @(negedge Clk);
      drive(8, 1'b1, 2'd2, 32'hC8, 32'h0A);   // held Start is ignored until DONE
      lat = 1;
      while (sel_done !== 1'b1 && lat < 200) begin
         @(negedge Clk);
         lat++;
      end
      tests_run++;
      if (lat !== 10 || sel_res !== 64'hFD99) begin
         tests_failed++;
         $display("FAIL b2b_first got lat=%0d res=%h want lat=10 res=fd99", lat, sel_res);
      end
      @(negedge Clk);
      drive(8, 1'b0, 2'd0, 32'h0, 32'h0);
      tests_run++;
      if (sel_res !== 64'hFD99 || sel_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_hold got res=%h busy=%b want res=fd99 busy=1", sel_res, sel_busy);
      end
      lat = 1;
      while (sel_done !== 1'b1 && lat < 200) begin
         @(negedge Clk);
         lat++;
      end
      tests_run++;
      if (lat !== 10 || sel_res !== 64'h0014) begin
         tests_failed++;
         $display("FAIL b2b_second got lat=%0d res=%h want lat=10 res=0014", lat, sel_res);
      end
   endtask

   task automatic test_reset_mid_calc;
      logic [63:0] res;
      logic dz, done_after;
      int lat, busy_n, active;
      run_op(8, 2'd2, 32'h2A, 32'h00, res, dz, lat, busy_n, done_after);
      tests_run++;
      if (res !== 64'h2AFF || dz !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_op got res=%h dz=%b want 2aff/1", res, dz);
      end
      @(negedge Clk);
      drive(8, 1'b1, 2'd0, 32'hFF, 32'hFF);
      @(negedge Clk);
      drive(8, 1'b0, 2'd0, 32'hFF, 32'hFF);
      repeat (3) @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      tests_run++;
      if ({busy8, done8, result8, dz8} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset got busy=%b done=%b res=%h dz=%b want all 0", busy8, done8, result8, dz8);
      end
      @(negedge Clk);
      Reset = 1'b0;
      active = 0;
      repeat (12) begin
         @(negedge Clk);
         if (busy8 === 1'b1 || done8 === 1'b1) active++;
      end
      tests_run++;
      if (active !== 0 || result8 !== 16'h0) begin
         tests_failed++;
         $display("FAIL idle_after_mid_reset got active=%0d res=%h want 0/0000", active, result8);
      end
      run_op(8, 2'd0, 32'h02, 32'h03, res, dz, lat, busy_n, done_after);
      tests_run++;
      if (res !== 64'h6 || lat !== 10) begin
         tests_failed++;
         $display("FAIL op_after_reset got res=%h lat=%0d want 0006/10", res, lat);
      end
   endtask

   task automatic test_random(input int w, input int n);
      logic [63:0] res, exp_res;
      logic dz, exp_dz, done_after;
      int lat, busy_n;
      logic [1:0]  op;
      logic [31:0] a, b, mask;
      for (int i = 0; i < n; i++) begin
         mask = (32'd1 << w) - 32'd1;
         op   = 2'($urandom);
         a    = $urandom & mask;
         b    = $urandom & mask;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'd1 << (w - 1); b = mask; end
            2: a = 32'd1 << (w - 1);
            default: ;
         endcase
         ref_model(w, op, a, b, exp_res, exp_dz);
         run_op(w, op, a, b, res, dz, lat, busy_n, done_after);
         tests_run++;
         if (res !== exp_res || dz !== exp_dz) begin
            tests_failed++;
            $display("FAIL rand_w%0d op=%0d a=%h b=%h got res=%h dz=%b want res=%h dz=%b",
                     w, op, a, b, res, dz, exp_res, exp_dz);
         end
         tests_run++;
         if (lat !== w + 2 || done_after !== 1'b0 || busy_n !== w + 1) begin
            tests_failed++;
            $display("FAIL rand_w%0d_timing got lat=%0d busy=%0d done_next=%b want lat=%0d busy=%0d done_next=0",
                     w, lat, busy_n, done_after, w + 2, w + 1);
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      drive(8, 1'b0, 2'd0, 32'h0, 32'h0);
      drive(16, 1'b0, 2'd0, 32'h0, 32'h0);
      drive(4, 1'b0, 2'd0, 32'h0, 32'h0);
      test_reset();
      test_directed();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_calc();
      test_random(16, 40);
      test_random(4, 40);
      test_random(8, 20);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
